wb_ram_arbiter: RTL and testbench
=================================

# wb_ram_arbiter

Two-requester Wishbone master arbiter that shares the single RAM master port between the video input writer (requester 0) and the video output reader (requester 1). It sits between the two video DMA-style masters and the system bus. Arbitration is round-robin with burst-length fairness and honours LOCK. An optional watchdog frees the bus when the slave stops acknowledging.

## Interface
Parameters:
- MAX_BURST, 16: beats (ACKs) an owner may take before it can be preempted; range 1–255.
- TIMEOUT, 255: wait cycles without ACK before watchdog fires; range 1–65535. Only used with ARB_TIMEOUT_EN.

Ports (clock and reset first; "mX" means one port each for m0 and m1):
- clk  input  1  system clock, 100 MHz
- nRST  input  1  reset, synchronous, active-low
- mX_wb_CYC_I  input  1  requester cycle / bus request
- mX_wb_STB_I  input  1  requester strobe
- mX_wb_LOCK_I  input  1  requester forbids preemption while high
- mX_wb_WE_I  input  1  requester write enable
- mX_wb_SEL_I  input  4  requester byte selects
- mX_wb_ADR_I  input  32  requester address
- mX_wb_DAT_I  input  32  requester write data
- mX_wb_ACK_O  output  1  ACK routed to owner only
- mX_wb_DAT_O  output  32  read data, broadcast from s_wb_DAT_I
- s_wb_CYC_O, s_wb_STB_O, s_wb_LOCK_O, s_wb_WE_O  output  1 each  muxed from owner
- s_wb_SEL_O  output  4  muxed
- s_wb_ADR_O, s_wb_DAT_O  output  32 each  muxed
- s_wb_ACK_I  input  1  slave acknowledge
- s_wb_DAT_I  input  32  slave read data
- grant  output  2  one-hot registered owner ({m1,m0}); 2'b00 when idle
- arb_timeout  output  1  one-cycle watchdog pulse

## Operation
- FSM states: IDLE, OWN0, OWN1. Registers: state, last (last owner), beat_cnt[7:0], wait_cnt[15:0].
- IDLE: if exactly one CYC_I high → OWN of that requester. If both high → requester != last. last resets to 1, so m0 wins first after reset.
- OWNx: all s_wb_* outputs are a combinational mux of requester x; mx_wb_ACK_O = s_wb_ACK_I; the other requester's ACK_O = 0.
- IDLE: all s_wb_* outputs 0; both ACK_O 0.
- OWNx → IDLE when mx_wb_CYC_I = 0 (release).
- OWNx → IDLE when beat_cnt = MAX_BURST, mx_wb_LOCK_I = 0, and the other CYC_I = 1 (preemption). The preempted master simply stalls without ACK until regranted.
- beat_cnt: cleared on entry to OWNx; incremented on s_wb_ACK_I while owned; saturates at MAX_BURST.
- On entry to OWNx, last ← x.
- Non-owner CYC/STB toggling has no effect on the slave port.
- ACK in the same cycle the owner drops CYC is not forwarded (STB is already low at the slave).

## Timing
- Reset: next clk edge with nRST = 0 → state IDLE, grant 2'b00, last 1, counters 0, arb_timeout 0, all s_wb_* 0, ACK_O 0. This also applies mid-burst.
- Grant latency: CYC_I rises at edge n → grant and s_wb_CYC_O high from edge n+1.
- Handover: minimum one cycle with s_wb_CYC_O = 0 between owners (the IDLE cycle). Owner change costs 2 cycles from the final ACK.
- Preemption is evaluated in the cycle after the MAX_BURST-th ACK. That ACK itself is delivered to the owner.
- Read data has zero latency through the arbiter: mX_wb_DAT_O = s_wb_DAT_I combinationally.

## Configuration
- ARB_TIMEOUT_EN defined:
  - wait_cnt counts cycles in OWNx with s_wb_STB_O = 1 and s_wb_ACK_I = 0; it clears on ACK or on state change.
  - When wait_cnt reaches TIMEOUT: arb_timeout pulses for 1 cycle, state → IDLE, and LOCK is ignored.
- ARB_TIMEOUT_EN undefined: no wait_cnt; arb_timeout is tied 0; the owner holds the bus indefinitely.

## Test plan
- m1 alone, 4-beat read, LOCK = 0, slave ACKs every cycle → grant = 2'b10 one cycle after CYC; 4 ACKs reach m1 only; m1 DAT_O tracks the slave; grant returns to 00 one cycle after CYC drops.
- m0 and m1 both raise CYC at the first cycle after reset → m0 granted. After m0 releases: one dead cycle, then grant = 2'b10.
- MAX_BURST = 4, m0 requests 10 beats, m1 requesting → m0 receives exactly 4 ACKs; s_wb_CYC_O is low for 1 cycle; m1 is served; m0 resumes afterwards at its 5th beat address.
- Same as previous but m0_wb_LOCK_I = 1 → m0 completes all 10 beats uninterrupted before m1 is granted.
- ARB_TIMEOUT_EN, TIMEOUT = 8, slave never ACKs m0 → arb_timeout high for exactly 1 cycle after 8 wait cycles; grant → 00. Without the macro: grant stays 2'b01 for the full 100 cycles observed.
- nRST low for 1 cycle during m1's 3rd beat → next edge all s_wb_* = 0 and grant = 00. With both requesting afterwards, m0 is granted first.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter
// Shares one Wishbone RAM master port between two requesters:
//   m0 = video input writer, m1 = video output reader.
// Round-robin arbitration with burst-length fairness (MAX_BURST ACKs before
// the owner may be preempted), LOCK honoured, optional slave watchdog.
//
// Ports:
//   clk, nRST            clock, synchronous active-low reset
//   mX_wb_*_I            requester X bus request (CYC/STB/LOCK/WE/SEL/ADR/DAT)
//   mX_wb_ACK_O          ACK routed to the current owner only
//   mX_wb_DAT_O          read data, broadcast from s_wb_DAT_I
//   s_wb_*_O             slave-side signals muxed from the owner (0 when idle)
//   s_wb_ACK_I/DAT_I     slave acknowledge / read data
//   grant                one-hot owner {m1,m0}, 2'b00 when idle
//   arb_timeout          one-cycle watchdog pulse
//
// Build option: define ARB_TIMEOUT_EN to enable the watchdog (TIMEOUT wait
// cycles without ACK frees the bus, ignoring LOCK). Without it arb_timeout
// is tied low and the owner keeps the bus indefinitely.
module wb_ram_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        m0_wb_CYC_I,
  input  logic        m0_wb_STB_I,
  input  logic        m0_wb_LOCK_I,
  input  logic        m0_wb_WE_I,
  input  logic [3:0]  m0_wb_SEL_I,
  input  logic [31:0] m0_wb_ADR_I,
  input  logic [31:0] m0_wb_DAT_I,
  output logic        m0_wb_ACK_O,
  output logic [31:0] m0_wb_DAT_O,
  input  logic        m1_wb_CYC_I,
  input  logic        m1_wb_STB_I,
  input  logic        m1_wb_LOCK_I,
  input  logic        m1_wb_WE_I,
  input  logic [3:0]  m1_wb_SEL_I,
  input  logic [31:0] m1_wb_ADR_I,
  input  logic [31:0] m1_wb_DAT_I,
  output logic        m1_wb_ACK_O,
  output logic [31:0] m1_wb_DAT_O,
  output logic        s_wb_CYC_O,
  output logic        s_wb_STB_O,
  output logic        s_wb_LOCK_O,
  output logic        s_wb_WE_O,
  output logic [3:0]  s_wb_SEL_O,
  output logic [31:0] s_wb_ADR_O,
  output logic [31:0] s_wb_DAT_O,
  input  logic        s_wb_ACK_I,
  input  logic [31:0] s_wb_DAT_I,
  output logic [1:0]  grant,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last;
  logic [7:0]  r_beat_cnt;

  logic w_own0, w_own1, w_owned;
  logic w_own_cyc, w_own_stb, w_own_lock, w_oth_cyc;
  logic w_preempt, w_stb_fwd, w_ack_fwd, w_timeout;

  assign w_own0     = (r_state == OWN0);
  assign w_own1     = (r_state == OWN1);
  assign w_owned    = w_own0 | w_own1;
  assign w_own_cyc  = w_own1 ? m1_wb_CYC_I  : m0_wb_CYC_I;
  assign w_own_stb  = w_own1 ? m1_wb_STB_I  : m0_wb_STB_I;
  assign w_own_lock = w_own1 ? m1_wb_LOCK_I : m0_wb_LOCK_I;
  assign w_oth_cyc  = w_own1 ? m0_wb_CYC_I  : m1_wb_CYC_I;

  // Burst quota used up, not locked, and the other side is waiting.
  assign w_preempt = w_owned && (r_beat_cnt == 8'(MAX_BURST)) &&
                     !w_own_lock && w_oth_cyc;

  // During the preemption cycle STB is withheld so the slave cannot hand the
  // owner an extra beat beyond its quota; CYC stays up until the IDLE cycle.
  assign w_stb_fwd = w_owned && w_own_stb && !w_preempt;

  // ACK reaches the owner only while it still holds CYC.
  assign w_ack_fwd = w_owned && w_own_cyc && !w_preempt && s_wb_ACK_I;

  assign grant       = {w_own1, w_own0};
  assign m0_wb_DAT_O = s_wb_DAT_I;
  assign m1_wb_DAT_O = s_wb_DAT_I;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] r_wait_cnt, w_wait_nxt;
  logic        r_arb_timeout;

  assign w_wait_nxt = (w_stb_fwd && !s_wb_ACK_I) ? r_wait_cnt + 16'd1 : 16'd0;
  assign w_timeout  = w_owned && w_own_cyc && (w_wait_nxt == 16'(TIMEOUT));
  assign arb_timeout = r_arb_timeout;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_wait_cnt    <= 16'd0;
      r_arb_timeout <= 1'b0;
    end else begin
      r_arb_timeout <= w_timeout;
      if (w_state_nxt != r_state) r_wait_cnt <= 16'd0;
      else if (w_owned)           r_wait_cnt <= w_wait_nxt;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout   = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_beat_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_state_nxt != IDLE) begin
        r_last     <= (w_state_nxt == OWN1);
        r_beat_cnt <= 8'd0;
      end else if (w_ack_fwd && r_beat_cnt != 8'(MAX_BURST)) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_wb_CYC_O  = 1'b0;
    s_wb_STB_O  = 1'b0;
    s_wb_LOCK_O = 1'b0;
    s_wb_WE_O   = 1'b0;
    s_wb_SEL_O  = 4'd0;
    s_wb_ADR_O  = 32'd0;
    s_wb_DAT_O  = 32'd0;
    m0_wb_ACK_O = 1'b0;
    m1_wb_ACK_O = 1'b0;
    case (r_state)
      IDLE: begin
        // Both requesting: the one that did not own the bus last wins.
        if (m0_wb_CYC_I && m1_wb_CYC_I) w_state_nxt = r_last ? OWN0 : OWN1;
        else if (m0_wb_CYC_I)           w_state_nxt = OWN0;
        else if (m1_wb_CYC_I)           w_state_nxt = OWN1;
      end
      OWN0: begin
        s_wb_CYC_O  = m0_wb_CYC_I;
        s_wb_STB_O  = w_stb_fwd;
        s_wb_LOCK_O = m0_wb_LOCK_I;
        s_wb_WE_O   = m0_wb_WE_I;
        s_wb_SEL_O  = m0_wb_SEL_I;
        s_wb_ADR_O  = m0_wb_ADR_I;
        s_wb_DAT_O  = m0_wb_DAT_I;
        m0_wb_ACK_O = w_ack_fwd;
        if (!w_own_cyc || w_timeout || w_preempt) w_state_nxt = IDLE;
      end
      OWN1: begin
        s_wb_CYC_O  = m1_wb_CYC_I;
        s_wb_STB_O  = w_stb_fwd;
        s_wb_LOCK_O = m1_wb_LOCK_I;
        s_wb_WE_O   = m1_wb_WE_I;
        s_wb_SEL_O  = m1_wb_SEL_I;
        s_wb_ADR_O  = m1_wb_ADR_I;
        s_wb_DAT_O  = m1_wb_DAT_I;
        m1_wb_ACK_O = w_ack_fwd;
        if (!w_own_cyc || w_timeout || w_preempt) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
module tb_wb_ram_arbiter;
  localparam int MB = 4;
  localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0, nRST;
  logic m0_wb_CYC_I, m0_wb_STB_I, m0_wb_LOCK_I, m0_wb_WE_I, m0_wb_ACK_O;
  logic m1_wb_CYC_I, m1_wb_STB_I, m1_wb_LOCK_I, m1_wb_WE_I, m1_wb_ACK_O;
  logic [3:0]  m0_wb_SEL_I, m1_wb_SEL_I, s_wb_SEL_O;
  logic [31:0] m0_wb_ADR_I, m0_wb_DAT_I, m0_wb_DAT_O;
  logic [31:0] m1_wb_ADR_I, m1_wb_DAT_I, m1_wb_DAT_O;
  logic s_wb_CYC_O, s_wb_STB_O, s_wb_LOCK_O, s_wb_WE_O, s_wb_ACK_I;
  logic [31:0] s_wb_ADR_O, s_wb_DAT_O, s_wb_DAT_I;
  logic [1:0]  grant;
  logic        arb_timeout;
  logic        ack_free, ack_auto;

  // Slave: either a free-running random ACK or "ACK every strobe".
  assign s_wb_ACK_I = ack_free | (ack_auto & s_wb_CYC_O & s_wb_STB_O);

  always #5 clk = ~clk;

  wb_ram_arbiter #(.MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .nRST(nRST),
    .m0_wb_CYC_I(m0_wb_CYC_I), .m0_wb_STB_I(m0_wb_STB_I), .m0_wb_LOCK_I(m0_wb_LOCK_I),
    .m0_wb_WE_I(m0_wb_WE_I), .m0_wb_SEL_I(m0_wb_SEL_I), .m0_wb_ADR_I(m0_wb_ADR_I),
    .m0_wb_DAT_I(m0_wb_DAT_I), .m0_wb_ACK_O(m0_wb_ACK_O), .m0_wb_DAT_O(m0_wb_DAT_O),
    .m1_wb_CYC_I(m1_wb_CYC_I), .m1_wb_STB_I(m1_wb_STB_I), .m1_wb_LOCK_I(m1_wb_LOCK_I),
    .m1_wb_WE_I(m1_wb_WE_I), .m1_wb_SEL_I(m1_wb_SEL_I), .m1_wb_ADR_I(m1_wb_ADR_I),
    .m1_wb_DAT_I(m1_wb_DAT_I), .m1_wb_ACK_O(m1_wb_ACK_O), .m1_wb_DAT_O(m1_wb_DAT_O),
    .s_wb_CYC_O(s_wb_CYC_O), .s_wb_STB_O(s_wb_STB_O), .s_wb_LOCK_O(s_wb_LOCK_O),
    .s_wb_WE_O(s_wb_WE_O), .s_wb_SEL_O(s_wb_SEL_O), .s_wb_ADR_O(s_wb_ADR_O),
    .s_wb_DAT_O(s_wb_DAT_O), .s_wb_ACK_I(s_wb_ACK_I), .s_wb_DAT_I(s_wb_DAT_I),
    .grant(grant), .arb_timeout(arb_timeout)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic clr_inputs();
    m0_wb_CYC_I = 0; m0_wb_STB_I = 0; m0_wb_LOCK_I = 0; m0_wb_WE_I = 0;
    m1_wb_CYC_I = 0; m1_wb_STB_I = 0; m1_wb_LOCK_I = 0; m1_wb_WE_I = 0;
    m0_wb_SEL_I = 4'hF; m1_wb_SEL_I = 4'hF;
    m0_wb_ADR_I = 32'h1000_0000; m1_wb_ADR_I = 32'h2000_0000;
    m0_wb_DAT_I = 32'hA0A0_0000; m1_wb_DAT_I = 32'hB1B1_0000;
    s_wb_DAT_I = 32'h0; ack_free = 0; ack_auto = 0;
  endtask

  // Called and returns at a falling edge; DUT is IDLE afterwards.
  task automatic do_reset();
    clr_inputs();
    nRST = 0;
    repeat (2) @(negedge clk);
    nRST = 1;
  endtask

  // Table row layout: {nRST, m0 CYC, m1 CYC, grant[1:0], s CYC, m0 ACK, m1 ACK}
  typedef struct packed {
    logic rn, c0, c1;
    logic [1:0] g;
    logic sc, a0, a1;
  } vec_t;
  vec_t tbl[25];

  task automatic run_table();
    logic [31:0] eadr;
    tbl[0]  = vec_t'(8'b1_0_1_00_0_0_0);  // m1 alone: request
    tbl[1]  = vec_t'(8'b1_0_1_10_1_0_1);  // beats 1..4
    tbl[2]  = vec_t'(8'b1_0_1_10_1_0_1);
    tbl[3]  = vec_t'(8'b1_0_1_10_1_0_1);
    tbl[4]  = vec_t'(8'b1_0_1_10_1_0_1);
    tbl[5]  = vec_t'(8'b1_0_0_10_0_0_0);  // m1 drops CYC
    tbl[6]  = vec_t'(8'b0_0_0_00_0_0_0);  // reset
    tbl[7]  = vec_t'(8'b1_1_1_00_0_0_0);  // both request after reset
    tbl[8]  = vec_t'(8'b1_1_1_01_1_1_0);  // m0 first
    tbl[9]  = vec_t'(8'b1_0_1_01_0_0_0);  // m0 releases
    tbl[10] = vec_t'(8'b1_0_1_00_0_0_0);  // dead cycle
    tbl[11] = vec_t'(8'b1_0_1_10_1_0_1);  // m1 granted
    tbl[12] = vec_t'(8'b1_0_0_10_0_0_0);
    tbl[13] = vec_t'(8'b1_0_0_00_0_0_0);
    tbl[14] = vec_t'(8'b1_0_1_00_0_0_0);  // m1 burst
    tbl[15] = vec_t'(8'b1_0_1_10_1_0_1);
    tbl[16] = vec_t'(8'b1_0_1_10_1_0_1);
    tbl[17] = vec_t'(8'b0_1_1_10_1_0_1);  // reset during 3rd beat
    tbl[18] = vec_t'(8'b1_1_1_00_0_0_0);  // all cleared, both request
    tbl[19] = vec_t'(8'b1_1_1_01_1_1_0);  // m0 wins
    tbl[20] = vec_t'(8'b0_1_1_01_1_1_0);  // reset while m0 owns (last=m0)
    tbl[21] = vec_t'(8'b1_1_1_00_0_0_0);
    tbl[22] = vec_t'(8'b1_1_1_01_1_1_0);  // last reset to m1 -> m0 again
    tbl[23] = vec_t'(8'b1_0_0_01_0_0_0);
    tbl[24] = vec_t'(8'b1_0_0_00_0_0_0);
    do_reset();
    ack_auto = 1;
    for (int i = 0; i < 25; i++) begin
      nRST = tbl[i].rn;
      m0_wb_CYC_I = tbl[i].c0; m0_wb_STB_I = tbl[i].c0;
      m1_wb_CYC_I = tbl[i].c1; m1_wb_STB_I = tbl[i].c1;
      s_wb_DAT_I = $urandom;
      #1;
      eadr = (tbl[i].g == 2'b01) ? 32'h1000_0000 : (tbl[i].g == 2'b10) ? 32'h2000_0000 : 32'h0;
      chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(tbl[i].g));
      chk($sformatf("tbl%0d_scyc", i), 64'(s_wb_CYC_O), 64'(tbl[i].sc));
      chk($sformatf("tbl%0d_ack", i), 64'({m1_wb_ACK_O, m0_wb_ACK_O}), 64'({tbl[i].a1, tbl[i].a0}));
      chk($sformatf("tbl%0d_adr", i), 64'(s_wb_ADR_O), 64'(eadr));
      chk($sformatf("tbl%0d_dato", i), 64'(m1_wb_DAT_O), 64'(s_wb_DAT_I));
      @(negedge clk);
    end
    nRST = 1;
  endtask

  // m0 wants 10 beats, m1 wants 2, slave ACKs every strobe.
  task automatic run_burst(input bit lock);
    int b0, b1, b0_before, low, i;
    logic [31:0] adr5;
    do_reset();
    ack_auto = 1;
    b0 = 0; b1 = 0; b0_before = 0; low = 0; adr5 = 0;
    for (i = 0; i < 200; i++) begin
      m0_wb_CYC_I = (b0 < 10); m0_wb_STB_I = (b0 < 10); m0_wb_LOCK_I = lock && (b0 < 10);
      m0_wb_ADR_I = 32'h100 + 32'(b0 * 4);
      m1_wb_CYC_I = (b1 < 2);  m1_wb_STB_I = (b1 < 2);
      m1_wb_ADR_I = 32'h200 + 32'(b1 * 4);
      #1;
      if (b0 >= 4 && b1 == 0 && !s_wb_CYC_O) low++;
      if (m0_wb_ACK_O) begin
        if (b0 == 4) adr5 = s_wb_ADR_O;
        if (b1 == 0) b0_before++;
        b0++;
      end
      if (m1_wb_ACK_O) b1++;
      @(negedge clk);
      if (b0 == 10 && b1 == 2) break;
    end
    chk(lock ? "lock_done" : "pre_done", 64'(i < 200), 64'(1));
    if (lock) begin
      chk("lock_m0_beats_first", 64'(b0_before), 64'(10));
    end else begin
      chk("pre_m0_beats_first", 64'(b0_before), 64'(MB));
      chk("pre_cyc_low_cycles", 64'(low), 64'(1));
      chk("pre_resume_adr", 64'(adr5), 64'(32'h110));
    end
    clr_inputs();
  endtask

  task automatic run_timeout();
    int first, gcnt, tcnt;
    do_reset();
    m0_wb_CYC_I = 1; m0_wb_STB_I = 1;
    first = -1; gcnt = 0; tcnt = 0;
    if (TO_EN) begin
      for (int i = 0; i < 40 && first < 0; i++) begin
        #1;
        if (arb_timeout) begin
          first = i;
          chk("to_grant_idle", 64'(grant), 64'(0));
        end else if (grant == 2'b01) gcnt++;
        @(negedge clk);
      end
      chk("to_fire_cycle", 64'(first), 64'(TO + 1));
      chk("to_wait_cycles", 64'(gcnt), 64'(TO));
      #1;
      chk("to_pulse_width", 64'(arb_timeout), 64'(0));
      @(negedge clk);
    end else begin
      @(negedge clk);
      for (int i = 0; i < 100; i++) begin
        #1;
        if (grant == 2'b01) gcnt++;
        if (arb_timeout) tcnt++;
        @(negedge clk);
      end
      chk("hold_grant_cycles", 64'(gcnt), 64'(100));
      chk("hold_no_timeout", 64'(tcnt), 64'(0));
    end
    clr_inputs();
  endtask

  // Random traffic against a rule-level reference model.
  task automatic run_random(input int cycles);
    int own, last, beats, waits, wn, o;
    bit to_pulse, pre, fwd;
    bit rc[2], rs[2], rl[2], rwe[2];
    logic [3:0] rsel[2];
    logic [31:0] radr[2], rdat[2];
    logic e_cyc, e_stb, e_lock, e_we, e_a0, e_a1;
    logic [3:0] e_sel;
    logic [31:0] e_adr, e_dat;
    logic [1:0] e_g;
    do_reset();
    own = -1; last = 1; beats = 0; waits = 0; to_pulse = 0;
    rc[0] = 0; rc[1] = 0; rl[0] = 0; rl[1] = 0;
    for (int n = 0; n < cycles; n++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(5) == 0) rc[k] = ~rc[k];
        if ($urandom_range(7) == 0) rl[k] = ~rl[k];
        rs[k] = ($urandom_range(7) != 0);
        rwe[k] = $urandom_range(1);
        rsel[k] = 4'($urandom);
        radr[k] = $urandom; rdat[k] = $urandom;
      end
      m0_wb_CYC_I = rc[0]; m0_wb_STB_I = rs[0]; m0_wb_LOCK_I = rl[0]; m0_wb_WE_I = rwe[0];
      m0_wb_SEL_I = rsel[0]; m0_wb_ADR_I = radr[0]; m0_wb_DAT_I = rdat[0];
      m1_wb_CYC_I = rc[1]; m1_wb_STB_I = rs[1]; m1_wb_LOCK_I = rl[1]; m1_wb_WE_I = rwe[1];
      m1_wb_SEL_I = rsel[1]; m1_wb_ADR_I = radr[1]; m1_wb_DAT_I = rdat[1];
      ack_free = $urandom_range(1);
      s_wb_DAT_I = $urandom;
      #1;
      e_cyc = 0; e_stb = 0; e_lock = 0; e_we = 0; e_sel = 0; e_adr = 0; e_dat = 0;
      e_a0 = 0; e_a1 = 0; e_g = 2'b00; pre = 0; fwd = 0;
      o = own;
      if (o >= 0) begin
        pre = (beats == MB) && !rl[o] && rc[1-o];
        e_cyc = rc[o]; e_stb = rs[o] && !pre; e_lock = rl[o]; e_we = rwe[o];
        e_sel = rsel[o]; e_adr = radr[o]; e_dat = rdat[o];
        fwd = ack_free && rc[o] && !pre;
        if (o == 0) begin e_a0 = fwd; e_g = 2'b01; end
        else        begin e_a1 = fwd; e_g = 2'b10; end
      end
      chk("rnd_grant", 64'(grant), 64'(e_g));
      chk("rnd_ctrl", 64'({s_wb_CYC_O, s_wb_STB_O, s_wb_LOCK_O, s_wb_WE_O, s_wb_SEL_O}),
          64'({e_cyc, e_stb, e_lock, e_we, e_sel}));
      chk("rnd_adr", 64'(s_wb_ADR_O), 64'(e_adr));
      chk("rnd_dat", 64'(s_wb_DAT_O), 64'(e_dat));
      chk("rnd_ack", 64'({m1_wb_ACK_O, m0_wb_ACK_O}), 64'({e_a1, e_a0}));
      chk("rnd_dato", 64'({m1_wb_DAT_O, m0_wb_DAT_O}), 64'({s_wb_DAT_I, s_wb_DAT_I}));
      chk("rnd_timeout", 64'(arb_timeout), 64'(to_pulse));
      // advance the model to the next clock edge
      to_pulse = 0;
      if (o < 0) begin
        if (rc[0] && rc[1]) own = (last == 1) ? 0 : 1;
        else if (rc[0])     own = 0;
        else if (rc[1])     own = 1;
        if (own >= 0) begin last = own; beats = 0; waits = 0; end
      end else begin
        wn = (e_stb && !ack_free) ? waits + 1 : 0;
        if (!rc[o]) own = -1;
        else if (TO_EN && wn == TO) begin own = -1; to_pulse = 1; end
        else if (pre) own = -1;
        else begin
          if (fwd && beats < MB) beats++;
          waits = wn;
        end
      end
      @(negedge clk);
    end
    clr_inputs();
  endtask

  initial begin
    clr_inputs();
    nRST = 0;
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_slave", 64'({s_wb_CYC_O, s_wb_STB_O, s_wb_LOCK_O, s_wb_WE_O, s_wb_SEL_O}), 64'(0));
    chk("rst_adr_dat", 64'({s_wb_ADR_O, s_wb_DAT_O}), 64'(0));
    chk("rst_acks", 64'({m1_wb_ACK_O, m0_wb_ACK_O}), 64'(0));
    chk("rst_timeout", 64'(arb_timeout), 64'(0));
    @(negedge clk);
    run_table();
    run_burst(1'b0);
    run_burst(1'b1);
    run_timeout();
    run_random(600);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
